// File: rtl/usb_token_tx_q.sv
// rtl/usb_token_tx_q.sv - queued USB token/SOF/handshake/special packet serialiser
// Requests wait in a small FIFO; the FSM pops one at a time and emits PID, payload and CRC5 bytes.
module usb_token_tx_q #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 2,
  parameter logic [4:0]  CRC_INIT   = 5'h1F
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [3:0]                    tx_pid_i,
  input  logic [6:0]                    tx_addr_i,
  input  logic [3:0]                    tx_endp_i,
  input  logic [10:0]                   tx_frame_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  output logic                          tx_pid_err_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          tx_to_sop_o,
  output logic                          tx_to_eop_o,
  output logic                          tx_to_valid_o,
  input  logic                          tx_to_ready_i,
  output logic [7:0]                    tx_to_data_o,
  output logic                          tx_con_pid_en_o,
  output logic [3:0]                    tx_con_pid_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [3:0]  GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  typedef struct packed {
    logic [3:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [10:0] frame;
  } req_t;

  typedef enum logic [2:0] {S_IDLE, S_B0, S_B1, S_B2, S_GAP} state_t;

  // Returns the CRC field already laid out for B2[7:3]: bit 0 is the first CRC bit on the wire.
  function automatic logic [4:0] crc5_field(input logic [10:0] d);
    logic [4:0] c;
    logic       fb;
    c = CRC_INIT;
    for (int i = 0; i < 11; i++) begin
      fb = d[i] ^ c[4];
      c  = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    end
    c = ~c;
    return {c[0], c[1], c[2], c[3], c[4]};
  endfunction

  req_t            mem [FIFO_DEPTH];
  req_t            req_in, head, pkt_q, pkt_d;
  logic [PW-1:0]   wr_q, rd_q;
  logic [LW-1:0]   level_q;
  state_t          state_q, state_d;
  logic [3:0]      gap_q, gap_d;
  logic [7:0]      data_q, data_d;
  logic [3:0]      con_pid_q, con_pid_d;
  logic            pid_err_q;
  logic            pid_ok, accept, push, pop, pkt_done;
  logic            is_token, is_sof;
  logic [10:0]     crc_src;
  logic [7:0]      byte1, byte2;

  assign req_in     = '{pid: tx_pid_i, addr: tx_addr_i, endp: tx_endp_i, frame: tx_frame_i};
  assign head       = mem[rd_q];
  assign tx_ready_o = (level_q != LW'(FIFO_DEPTH));
  assign pid_ok     = (tx_pid_i[1:0] != 2'b11) && (tx_pid_i != 4'b0000);
  assign accept     = tx_valid_i && tx_ready_o;
  assign push       = accept && pid_ok;

  assign is_token = (pkt_q.pid[1:0] == 2'b01);
  assign is_sof   = (pkt_q.pid == 4'b0101);
  assign crc_src  = is_sof ? pkt_q.frame : {pkt_q.endp, pkt_q.addr};
  assign byte1    = is_sof ? pkt_q.frame[7:0] : {pkt_q.endp[0], pkt_q.addr};
  assign byte2    = {crc5_field(crc_src), is_sof ? pkt_q.frame[10:8] : pkt_q.endp[3:1]};

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_q] <= req_in;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q      <= '0;
      rd_q      <= '0;
      level_q   <= '0;
      pid_err_q <= 1'b0;
      state_q   <= S_IDLE;
      gap_q     <= 4'd0;
      data_q    <= 8'd0;
      con_pid_q <= 4'd0;
      pkt_q     <= '0;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      level_q   <= level_q + LW'(push) - LW'(pop);
      pid_err_q <= accept && !pid_ok;
      state_q   <= state_d;
      gap_q     <= gap_d;
      data_q    <= data_d;
      con_pid_q <= con_pid_d;
      pkt_q     <= pkt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    data_d    = data_q;
    con_pid_d = con_pid_q;
    pkt_d     = pkt_q;
    pop       = 1'b0;
    pkt_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (level_q != '0) begin
          pop       = 1'b1;
          pkt_d     = head;
          data_d    = {~head.pid, head.pid};
          con_pid_d = head.pid;
          state_d   = S_B0;
        end
      end
      S_B0: begin
        if (tx_to_ready_i) begin
          if (is_token) begin
            state_d = S_B1;
            data_d  = byte1;
          end else begin
            pkt_done = 1'b1;
          end
        end
      end
      S_B1: begin
        if (tx_to_ready_i) begin
          state_d = S_B2;
          data_d  = byte2;
        end
      end
      S_B2: begin
        if (tx_to_ready_i) pkt_done = 1'b1;
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
          gap_d   = 4'd0;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pkt_done) begin
      state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      gap_d   = 4'd0;
    end
  end

  assign tx_to_valid_o   = (state_q == S_B0) || (state_q == S_B1) || (state_q == S_B2);
  assign tx_to_sop_o     = (state_q == S_B0);
  assign tx_to_eop_o     = (state_q == S_B2) || ((state_q == S_B0) && !is_token);
  assign tx_to_data_o    = data_q;
  assign tx_con_pid_en_o = (state_q == S_B0);
  assign tx_con_pid_o    = con_pid_q;
  assign tx_pid_err_o    = pid_err_q;
  assign fifo_level_o    = level_q;

endmodule

// File: tb/tb_usb_token_tx_q.sv
// tb/tb_usb_token_tx_q.sv - scoreboard bench for usb_token_tx_q
// Driver pushes expected bytes from a reference model; a negedge monitor pops and compares.
module tb_usb_token_tx_q;

  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  tx_pid = '0;
  logic [6:0]  tx_addr = '0;
  logic [3:0]  tx_endp = '0;
  logic [10:0] tx_frame = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready, tx_pid_err;
  logic [2:0]  fifo_level;
  logic        tx_to_sop, tx_to_eop, tx_to_valid;
  logic        tx_to_ready = 1'b0;
  logic [7:0]  tx_to_data;
  logic        tx_con_pid_en;
  logic [3:0]  tx_con_pid;

  usb_token_tx_q #(.FIFO_DEPTH(4), .GAP_CYCLES(GAP), .CRC_INIT(5'h1F)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .tx_pid_i(tx_pid), .tx_addr_i(tx_addr), .tx_endp_i(tx_endp), .tx_frame_i(tx_frame),
    .tx_valid_i(tx_valid), .tx_ready_o(tx_ready), .tx_pid_err_o(tx_pid_err),
    .fifo_level_o(fifo_level), .tx_to_sop_o(tx_to_sop), .tx_to_eop_o(tx_to_eop),
    .tx_to_valid_o(tx_to_valid), .tx_to_ready_i(tx_to_ready), .tx_to_data_o(tx_to_data),
    .tx_con_pid_en_o(tx_con_pid_en), .tx_con_pid_o(tx_con_pid)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  logic [9:0] exp_q[$];
  logic [7:0] seen[$];
  int         ready_mode = 1;
  logic       manual_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (bound expired or unexpected event)", name);
  endtask

  // CRC5 as polynomial division of the seeded, wire-ordered 11-bit field.
  function automatic logic [4:0] model_crc_field(input logic [10:0] d);
    logic [31:0] v;
    logic [4:0]  crc;
    v = 32'd0;
    for (int i = 0; i < 11; i++) v = (v << 1) | 32'(d[i]);
    v = (v ^ (32'h1F << 6)) << 5;
    for (int b = 15; b >= 5; b--) if (v[b]) v = v ^ (32'h25 << (b - 5));
    crc = ~v[4:0];
    return {crc[0], crc[1], crc[2], crc[3], crc[4]};
  endfunction

  function automatic void model_push(input logic [3:0] pid, input logic [6:0] addr,
                                     input logic [3:0] endp, input logic [10:0] frame);
    logic [7:0]  b0;
    logic [10:0] d;
    logic        sof;
    b0  = {~pid, pid};
    sof = (pid == 4'b0101);
    if (pid[1:0] == 2'b01) begin
      d = sof ? frame : {endp, addr};
      exp_q.push_back({2'b10, b0});
      exp_q.push_back({2'b00, sof ? frame[7:0] : {endp[0], addr}});
      exp_q.push_back({2'b01, model_crc_field(d), sof ? frame[10:8] : endp[3:1]});
    end else begin
      exp_q.push_back({2'b11, b0});
    end
  endfunction

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       tx_to_ready = 1'b0;
      1:       tx_to_ready = 1'b1;
      2:       tx_to_ready = ($urandom_range(0, 3) != 0);
      default: tx_to_ready = manual_ready;
    endcase
  end

  task automatic send(input logic [3:0] pid, input logic [6:0] addr,
                      input logic [3:0] endp, input logic [10:0] frame);
    int         n;
    logic       err, ok;
    logic [2:0] lvl;
    n   = 0;
    err = (pid[1:0] == 2'b11) || (pid == 4'b0000);
    tx_pid = pid; tx_addr = addr; tx_endp = endp; tx_frame = frame; tx_valid = 1'b1;
    @(negedge clk);
    while (!tx_ready && n < 300) begin @(negedge clk); n++; end
    ok  = tx_ready;
    lvl = fifo_level;
    if (!ok) fail_now("send_timeout");
    else if (!err) model_push(pid, addr, endp, frame);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    if (err && ok) begin
      @(negedge clk);
      chk("pid_err_pulse", tx_pid_err, 1);
      chk("pid_err_level", fifo_level, lvl);
      @(negedge clk);
      chk("pid_err_clear", tx_pid_err, 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || tx_to_valid) && n < 3000) begin @(negedge clk); n++; end
    if (exp_q.size() != 0 || tx_to_valid) fail_now("drain_timeout");
    repeat (GAP + 2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  logic       after_eop = 1'b0, exact = 1'b0, stall = 1'b0;
  int         idle_cnt = 0;
  logic [7:0] last_byte = '0;
  logic [9:0] prev_beat = '0;
  logic [9:0] e;

  always @(negedge clk) begin
    if (!rst_n) begin
      after_eop = 1'b0;
      stall     = 1'b0;
    end else if (tx_to_valid) begin
      if (after_eop) begin
        if (exact) chk("gap_exact", idle_cnt, GAP + 1);
        else       chk("gap_min", idle_cnt >= GAP + 1, 1);
        after_eop = 1'b0;
      end
      if (stall) chk("stall_hold", {tx_to_sop, tx_to_eop, tx_to_data}, prev_beat);
      chk("pid_en", tx_con_pid_en, tx_to_sop);
      if (tx_to_sop) chk("con_pid", tx_con_pid, tx_to_data[3:0]);
      if (tx_to_ready) begin
        stall = 1'b0;
        if (exp_q.size() == 0) fail_now("unexpected_byte");
        else begin
          e = exp_q.pop_front();
          chk("byte", {tx_to_sop, tx_to_eop, tx_to_data}, e);
        end
        seen.push_back(tx_to_data);
        if (tx_to_eop) begin
          after_eop = 1'b1;
          idle_cnt  = 0;
          exact     = (exp_q.size() != 0);
          last_byte = tx_to_data;
        end
      end else begin
        stall     = 1'b1;
        prev_beat = {tx_to_sop, tx_to_eop, tx_to_data};
      end
    end else begin
      stall = 1'b0;
      chk("idle_flags", {tx_to_sop, tx_to_eop, tx_con_pid_en}, 0);
      if (after_eop) begin
        idle_cnt++;
        chk("idle_data_hold", tx_to_data, last_byte);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] pid;
    int         n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", tx_to_valid, 0);
    chk("rst_flags", {tx_to_sop, tx_to_eop, tx_con_pid_en, tx_pid_err}, 0);
    chk("rst_data", tx_to_data, 0);
    chk("rst_con_pid", tx_con_pid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", tx_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    ready_mode = 1;
    seen.delete();
    send(4'hD, 7'd0, 4'd0, 11'd0);
    wait_drain();
    chk("setup_len", seen.size(), 3);
    if (seen.size() == 3) begin
      chk("setup_b0", seen[0], 8'h2D);
      chk("setup_b1", seen[1], 8'h00);
      chk("setup_b2", seen[2], 8'h10);
    end

    seen.delete();
    send(4'h2, 7'd0, 4'd0, 11'd0);
    send(4'h2, 7'd0, 4'd0, 11'd0);
    wait_drain();
    chk("ack_len", seen.size(), 2);
    if (seen.size() == 2) chk("ack_b0", seen[0], 8'hD2);

    ready_mode = 2;
    for (int f = 0; f < 2048; f++) send(4'h5, 7'($urandom), 4'($urandom), 11'(f));
    wait_drain();
    for (int k = 0; k < 300; k++) begin
      do pid = 4'($urandom); while (pid[1:0] == 2'b11 || pid == 4'h0);
      send(pid, 7'($urandom), 4'($urandom), 11'($urandom));
    end
    wait_drain();

    ready_mode = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) send(4'h9, 7'($urandom), 4'($urandom), 11'd0);
    @(negedge clk);
    chk("full_level", fifo_level, 4);
    chk("full_ready", tx_ready, 0);
    @(posedge clk); #1;
    ready_mode = 1;
    wait_drain();
    chk("drained_level", fifo_level, 0);

    send(4'h3, 7'd1, 4'd1, 11'd0);
    send(4'h0, 7'd1, 4'd1, 11'd0);
    send(4'hB, 7'd1, 4'd1, 11'd0);
    repeat (4) @(posedge clk);
    #1;

    ready_mode   = 3;
    manual_ready = 1'b0;
    @(posedge clk); #1;
    send(4'hD, 7'd5, 4'd3, 11'd0);
    n = 0;
    @(negedge clk);
    while (!(tx_to_valid && tx_to_sop) && n < 20) begin @(negedge clk); n++; end
    if (!(tx_to_valid && tx_to_sop)) fail_now("b0_timeout");
    manual_ready = 1'b1;
    @(posedge clk); #2;
    manual_ready = 1'b0;
    @(posedge clk); #2;
    @(negedge clk);
    chk("b1_valid", tx_to_valid, 1);
    chk("b1_sop", tx_to_sop, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", tx_to_valid, 0);
    chk("mid_rst_flags", {tx_to_sop, tx_to_eop, tx_con_pid_en, tx_pid_err}, 0);
    chk("mid_rst_data", tx_to_data, 0);
    chk("mid_rst_con_pid", tx_con_pid, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_ready", tx_ready, 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 1;
    repeat (6) @(posedge clk);
    #1;
    seen.delete();
    send(4'hD, 7'd5, 4'd3, 11'd0);
    wait_drain();
    chk("restart_len", seen.size(), 3);
    if (seen.size() == 3) chk("restart_b0", seen[0], 8'h2D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
